// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control: EX/MEM/WB scoreboard, stall/flush/freeze, halt drain, stall counter.
// Define FORWARDING_EN to reduce RAW stalls to load-use and produce EX forwarding selects.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW       = 4,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              id_use_rs_i,
    input  logic              id_use_rt_i,
    input  logic              id_reg_write_i,
    input  logic              id_is_load_i,
    input  logic              id_is_halt_i,
    input  logic              ex_branch_taken_i,
    input  logic              mem_busy_i,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              flush_d_o,
    output logic              flush_e_o,
    output logic              freeze_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              hlt_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    localparam int unsigned DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              reg_write;
        logic              is_load;
        logic              use_rs;
        logic              use_rt;
    } slot_t;

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    slot_t            ex_q, mem_q, wb_q, ex_d;
    state_e           state_q;
    logic [DW-1:0]    drain_q;
    logic             hlt_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             raw_hazard;
    logic             run;
    logic             halt_accept;
    logic             ex_load;

    function automatic logic reads_slot(slot_t s, logic use_rs, logic use_rt,
                                        logic [REG_AW-1:0] rs, logic [REG_AW-1:0] rt);
        return s.valid & s.reg_write & ((use_rs & (rs == s.rd)) | (use_rt & (rt == s.rd)));
    endfunction

`ifdef FORWARDING_EN
    // Newest producer wins: MEM result is younger than WB.
    function automatic logic [1:0] fwd_sel(logic use_src, logic [REG_AW-1:0] src,
                                           slot_t m, slot_t w);
        if (use_src & m.valid & m.reg_write & (m.rd == src)) begin
            return 2'b01;
        end
        if (use_src & w.valid & w.reg_write & (w.rd == src)) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    always_comb begin
        raw_hazard  = id_valid_i & ex_q.is_load &
                      reads_slot(ex_q, id_use_rs_i, id_use_rt_i, id_rs_i, id_rt_i);
        fwd_a_sel_o = fwd_sel(ex_q.valid & ex_q.use_rs, ex_q.rs, mem_q, wb_q);
        fwd_b_sel_o = fwd_sel(ex_q.valid & ex_q.use_rt, ex_q.rt, mem_q, wb_q);
    end
`else
    always_comb begin
        raw_hazard  = id_valid_i &
                      (reads_slot(ex_q, id_use_rs_i, id_use_rt_i, id_rs_i, id_rt_i) |
                       reads_slot(mem_q, id_use_rs_i, id_use_rt_i, id_rs_i, id_rt_i));
        fwd_a_sel_o = 2'b00;
        fwd_b_sel_o = 2'b00;
    end
`endif

    logic unused_slot_bits;
    assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

    assign run = (state_q == StRun);

    always_comb begin
        freeze_o  = mem_busy_i;
        stall_f_o = 1'b0;
        stall_d_o = 1'b0;
        flush_d_o = 1'b0;
        flush_e_o = 1'b0;
        if (mem_busy_i) begin
            // Frozen: every other control stays low.
        end else if (!run) begin
            stall_f_o = 1'b1;
            flush_d_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            flush_d_o = 1'b1;
            flush_e_o = 1'b1;
        end else if (raw_hazard) begin
            stall_f_o = 1'b1;
            stall_d_o = 1'b1;
        end
    end

    assign halt_accept = run & ~freeze_o & id_valid_i & id_is_halt_i & ~stall_d_o & ~flush_d_o;
    assign ex_load     = run & id_valid_i & ~stall_d_o & ~flush_e_o;

    always_comb begin
        ex_d = '0;
        if (ex_load) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = id_rd_i;
            ex_d.rs        = id_rs_i;
            ex_d.rt        = id_rt_i;
            ex_d.reg_write = id_reg_write_i;
            ex_d.is_load   = id_is_load_i;
            ex_d.use_rs    = id_use_rs_i;
            ex_d.use_rt    = id_use_rt_i;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_d_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (!freeze_o) begin
                wb_q  <= mem_q;
                mem_q <= ex_q;
                ex_q  <= ex_d;
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StRun;
            drain_q <= '0;
            hlt_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (halt_accept) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_q <= StHalted;
                            hlt_q   <= 1'b1;
                        end else begin
                            state_q <= StDrain;
                            drain_q <= DW'(DRAIN_CYCLES);
                        end
                    end
                end
                StDrain: begin
                    if (!freeze_o) begin
                        if (drain_q <= DW'(1)) begin
                            state_q <= StHalted;
                            drain_q <= '0;
                            hlt_q   <= 1'b1;
                        end else begin
                            drain_q <= drain_q - DW'(1);
                        end
                    end
                end
                StHalted: begin
                    hlt_q <= 1'b1;
                end
                default: begin
                    state_q <= StRun;
                    drain_q <= '0;
                    hlt_q   <= 1'b0;
                end
            endcase
        end
    end

    assign hlt_o          = hlt_q;
    assign stall_cycles_o = stall_cnt_q;

endmodule
